kbd_fifo_port: RTL and testbench
================================

KBD_FIFO_PORT -- requirements
Module: kbd_fifo_port

Keyboard PIA-side port: buffers ASCII bytes from the keyboard decoder and serves the CPU reads at 0xD010 (KBD) and 0xD011 (KBDCR).

Interface
- REQ-001: Parameter DEPTH, default 8, FIFO entries; power of 2, 2..64.
- REQ-002: clk14  input  1  14 MHz master clock; all logic on rising edge.
- REQ-003: rst  input  1  synchronous reset, active-high.
- REQ-004: enable  input  1  CPU clock enable; bus side effects occur only when high.
- REQ-005: cs  input  1  chip select, 0xD010-0xD011 decoded.
- REQ-006: address  input  1  0 = KBD, 1 = KBDCR.
- REQ-007: we  input  1  CPU write strobe; high = write cycle.
- REQ-008: dout  output  8  read data, combinational from registered state.
- REQ-009: key_valid  input  1  upstream byte available.
- REQ-010: key_data  input  7  upstream ASCII code.
- REQ-011: key_ready  output  1  FIFO can accept a byte.
- REQ-012: count  output  log2(DEPTH)+1  current occupancy.
- REQ-013: overflow  output  1  sticky flag: a byte was offered while full.

Function
- REQ-014: key_ready SHALL equal (count != DEPTH); push occurs on a clock where key_valid & key_ready.
- REQ-015: Pushed codes 0x61-0x7A SHALL be stored as code - 0x20 (upper case); all other codes stored unchanged.
- REQ-016: Pop SHALL occur on a clock where enable & cs & !we & !address & (count != 0).
- REQ-017: Read of KBD with count != 0 SHALL return {1'b1, head[6:0]}; with count == 0, {1'b0, last[6:0]}, where last holds the most recently popped byte.
- REQ-018: Read of KBDCR SHALL return {(count != 0), 7'b0} and SHALL NOT pop.
- REQ-019: dout SHALL be 8'h00 when cs is low.
- REQ-020: CPU writes (we high) to either address SHALL be ignored: no state change.
- REQ-021: Simultaneous push and pop SHALL leave count unchanged; the popped byte is the old head, and the new byte goes to tail.
- REQ-022: Pop with count == 0 SHALL be a no-op; last is unchanged.
- REQ-023: Push with count == DEPTH cannot occur (key_ready low); key_valid high in that state SHALL set overflow, and the byte is not stored.
- REQ-024: Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
- REQ-025: Pop and push each take effect at the clock edge they qualify on; a pushed byte SHALL be readable at KBD on the next cycle (1-cycle latency).
- REQ-026: overflow SHALL clear only on rst.
- REQ-027: Bus actions with enable low SHALL have no side effects; dout still reflects current state.

Reset
- REQ-028: On rst high at a clock edge: count = 0, pointers = 0, last = 7'h00, overflow = 0.
- REQ-029: After reset: key_ready = 1; KBD read returns 8'h00; KBDCR read returns 8'h00.
- REQ-030: rst SHALL take priority over a simultaneous push or pop; FIFO contents are discarded.

Verification
- REQ-031: Push 0x61 ('a'), then read KBDCR -> 8'h80; read KBD -> 8'hC1, count 1 -> 0; next KBD read -> 8'h41.
- REQ-032: Push 9 bytes 0x30..0x38 back-to-back with DEPTH=8 -> key_ready low after the 8th, overflow = 1, count = 8; eight KBD pops return 8'hB0..8'hB7 in order.
- REQ-033: count = 3, push 0x0D and pop in the same cycle -> count stays 3, popped = old head, 0x0D emerges 3 pops later as 8'h8D.
- REQ-034: KBD read with enable low, and a write of 8'hA7 to KBDCR -> count unchanged, no pop, no state change.
- REQ-035: Fill 5 bytes, assert rst for one cycle while key_valid is high -> count 0, overflow 0, KBD read 8'h00.
- REQ-036: 20 push/pop cycles crossing the pointer wrap -> output order equals input order, with no loss or duplication.

Source files
------------

// File: rtl/kbd_fifo_port.sv
// Keyboard PIA-side port: FIFO of ASCII bytes from the keyboard decoder,
// CPU reads at KBD (address 0, pops) and KBDCR (address 1, status only).
//
// Ports:
//   clk14      14 MHz master clock, all logic on its rising edge
//   rst        synchronous reset, active-high
//   enable     CPU clock enable; bus side effects only when high
//   cs         chip select for the KBD/KBDCR pair
//   address    0 = KBD, 1 = KBDCR
//   we         CPU write strobe (writes are ignored)
//   dout       read data, 8'h00 when cs is low
//   key_valid  upstream byte available
//   key_data   upstream 7-bit ASCII code
//   key_ready  FIFO can accept a byte
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: a byte was offered while full
module kbd_fifo_port #(
  parameter int DEPTH = 8
) (
  input  logic                     clk14,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     cs,
  input  logic                     address,
  input  logic                     we,
  output logic [7:0]               dout,
  input  logic                     key_valid,
  input  logic [6:0]               key_data,
  output logic                     key_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic [6:0]    last;
  logic          overflow_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [6:0]    code_up;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Pop only on an enabled CPU read of KBD with data present.
  assign push = key_valid & ~full;
  assign pop  = enable & cs & ~we & ~address & ~empty;

  // Lower-case letters are folded to upper case on the way in.
  always_comb begin
    code_up = key_data;
    if (key_data >= 7'h61 && key_data <= 7'h7A)
      code_up = key_data - 7'h20;
  end

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk14) begin
    if (push)
      mem[wr_ptr] <= code_up;
  end

  always_ff @(posedge clk14) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      last       <= 7'h00;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last   <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (key_valid & full)
        overflow_q <= 1'b1;
    end
  end

  // Read mux: KBD shows head with strobe bit, or the last popped byte.
  always_comb begin
    dout = 8'h00;
    if (cs) begin
      unique case (1'b1)
        address:        dout = {~empty, 7'b0};
        (!address && !empty): dout = {1'b1, mem[rd_ptr]};
        default:        dout = {1'b0, last};
      endcase
    end
  end

  assign key_ready = ~full;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_kbd_fifo_port.sv
// Self-checking bench for kbd_fifo_port: queue-based reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_kbd_fifo_port;

  localparam int DEPTH = 8;

  logic       clk14 = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       cs = 1'b0;
  logic       address = 1'b0;
  logic       we = 1'b0;
  logic [7:0] dout;
  logic       key_valid = 1'b0;
  logic [6:0] key_data = 7'h00;
  logic       key_ready;
  logic [3:0] count;
  logic       overflow;

  kbd_fifo_port #(.DEPTH(DEPTH)) dut (
    .clk14(clk14), .rst(rst), .enable(enable), .cs(cs),
    .address(address), .we(we), .dout(dout),
    .key_valid(key_valid), .key_data(key_data),
    .key_ready(key_ready), .count(count), .overflow(overflow)
  );

  always #5 clk14 = ~clk14;

  // Reference model
  logic [6:0] q[$];
  logic [6:0] last_m;
  logic       ovf_m;

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] upc(input logic [6:0] c);
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_dout();
    if (!cs) return 8'h00;
    if (address) return {q.size() != 0, 7'b0};
    if (q.size() != 0) return {1'b1, q[0]};
    return {1'b0, last_m};
  endfunction

  // One clock: compare outputs against the model (and an optional
  // literal), then advance the model across the rising edge.
  task automatic cycle(input string nm, input bit use_lit = 0,
                       input logic [7:0] lit = 8'h00);
    bit do_pop, do_push, ovf_set;
    logic [6:0] d;
    #1;
    chk({nm, ".dout"}, dout, exp_dout());
    chk({nm, ".ready"}, {7'b0, key_ready},
        {7'b0, q.size() != DEPTH});
    chk({nm, ".count"}, {4'b0, count}, 8'(q.size()));
    chk({nm, ".ovf"}, {7'b0, overflow}, {7'b0, ovf_m});
    if (use_lit) chk({nm, ".lit"}, dout, lit);
    do_pop  = enable && cs && !we && !address && q.size() != 0;
    do_push = key_valid && q.size() != DEPTH;
    ovf_set = key_valid && q.size() == DEPTH;
    d = upc(key_data);
    @(posedge clk14);
    if (rst) begin
      q.delete();
      last_m = 7'h00;
      ovf_m  = 1'b0;
    end else begin
      if (ovf_set) ovf_m = 1'b1;
      if (do_pop) last_m = q.pop_front();
      if (do_push) q.push_back(d);
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; enable = 0; cs = 0; address = 0; we = 0;
    key_valid = 0; key_data = 7'h00;
  endtask

  task automatic do_rst();
    idle();
    rst = 1;
    cycle("rst");
    rst = 0;
  endtask

  task automatic rd(input logic a);
    enable = 1; cs = 1; we = 0; address = a;
  endtask

  initial begin
    last_m = 7'h00;
    ovf_m  = 1'b0;
    rst = 1;
    @(posedge clk14);
    #1;
    rst = 0;

    // Reset state
    rd(0); cycle("rst_kbd", 1, 8'h00);
    rd(1); cycle("rst_cr", 1, 8'h00);

    // Lower-case fold, status, pop, last
    idle(); key_valid = 1; key_data = 7'h61; cycle("a_push");
    idle(); rd(1); cycle("a_cr", 1, 8'h80);
    rd(0); cycle("a_kbd", 1, 8'hC1);
    cycle("a_last", 1, 8'h41);

    // Fill past full
    do_rst();
    for (int i = 0; i < 9; i++) begin
      key_valid = 1; key_data = 7'(7'h30 + i);
      cycle("fill");
    end
    idle(); cycle("full");
    for (int i = 0; i < 8; i++) begin
      rd(0); cycle("drain", 1, 8'(8'hB0 + i));
    end

    // Simultaneous push and pop
    do_rst();
    for (int i = 0; i < 3; i++) begin
      key_valid = 1; key_data = 7'(7'h41 + i);
      cycle("pp_fill");
    end
    rd(0); key_valid = 1; key_data = 7'h0D;
    cycle("pp_both", 1, 8'hC1);
    key_valid = 0;
    cycle("pp_p1", 1, 8'hC2);
    cycle("pp_p2", 1, 8'hC3);
    cycle("pp_p3", 1, 8'h8D);

    // Enable low read, write to KBDCR
    idle(); key_valid = 1; key_data = 7'h55; cycle("ign_push");
    idle(); cs = 1; address = 0; cycle("ign_noen", 1, 8'hD5);
    enable = 1; we = 1; address = 1; cycle("ign_wr");
    we = 1; address = 0; cycle("ign_wr0");
    idle(); rd(0); cycle("ign_chk", 1, 8'hD5);

    // Reset while pushing
    do_rst();
    for (int i = 0; i < 5; i++) begin
      key_valid = 1; key_data = 7'(7'h61 + i);
      cycle("r5_fill");
    end
    rst = 1; key_valid = 1; cycle("r5_rst");
    idle(); rd(0); cycle("r5_kbd", 1, 8'h00);

    // Random traffic across pointer wrap
    idle();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      cs        = ($urandom_range(0, 3) != 0);
      address   = ($urandom_range(0, 4) == 0);
      we        = ($urandom_range(0, 5) == 0);
      key_valid = ($urandom_range(0, 1) == 1);
      key_data  = 7'($urandom);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
